// File: rtl/freq_m_sched.sv
// freq_m_sched: time-shares one frequency-counter datapath across up to four
// input channels. For each channel it selects the mux, clears the counter,
// opens a gate window, lets the counter settle and captures a scaled result.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start
// S_SELECT   | ch_sel driven, SETTLE cycles for the mux to settle
// S_CLEAR    | cnt_clr high for CLR_CYCLES cycles, sticky ovf cleared
// S_GATE     | cnt_en high for exactly G cycles
// S_HOLD     | cnt_en low, SETTLE cycles for the count to become stable
// S_CAPTURE  | scale the count; load the result register if it can take it
// S_WAIT_BUF | result pending, waiting for res_ack to free the register
module freq_m_sched #(
    parameter int unsigned FREQ_BASE  = 50_000_000,
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned CLR_CYCLES = 4
) (
    input  logic        clk_base,
    input  logic        rst_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [3:0]  ch_mask,
    input  logic [1:0]  gate_sel,
    input  logic [31:0] cnt_value,
    input  logic        cnt_ovf,
    output logic [1:0]  ch_sel,
    output logic        cnt_clr,
    output logic        cnt_en,
    output logic        res_valid,
    input  logic        res_ack,
    output logic [1:0]  res_ch,
    output logic [31:0] res_freq,
    output logic        res_ovf,
    output logic        busy,
    output logic        sweep_done,
    output logic        err_no_ch
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_CLEAR    = 3'd2;
    localparam logic [2:0] S_GATE     = 3'd3;
    localparam logic [2:0] S_HOLD     = 3'd4;
    localparam logic [2:0] S_CAPTURE  = 3'd5;
    localparam logic [2:0] S_WAIT_BUF = 3'd6;

    // Timers are down-counters loaded with (length - 1); the state ends when
    // the count reaches zero.
    localparam logic [31:0] SETTLE_LD = 32'(SETTLE - 1);
    localparam logic [31:0] CLR_LD    = 32'(CLR_CYCLES - 1);
    localparam logic [31:0] GATE_LD0  = 32'(FREQ_BASE - 1);
    localparam logic [31:0] GATE_LD1  = 32'(FREQ_BASE / 10 - 1);
    localparam logic [31:0] GATE_LD2  = 32'(FREQ_BASE / 100 - 1);
    localparam logic [31:0] GATE_LD3  = 32'(FREQ_BASE / 1000 - 1);

    logic [2:0]  state;
    logic [31:0] tmr;
    logic        tmr_tc;
    logic [3:0]  mask_q;
    logic [1:0]  cur_ch;
    logic [1:0]  gsel_q;
    logic        ovf_sticky;
    logic [31:0] pend_freq;
    logic        pend_ovf;

    logic [31:0] gate_ld;
    logic [9:0]  mult;
    logic [41:0] prod;
    logic        cap_sat;
    logic [31:0] cap_freq;
    logic        cap_ovf;
    logic        do_load;

    logic [2:0]  first_pick;
    logic [2:0]  next_pick;
    logic        adv_sel;
    logic        adv_relatch;
    logic        adv_err;
    logic        adv_done;
    logic [1:0]  adv_ch;

    // Lowest set mask bit, either overall or strictly above cur; {found, index}.
    function automatic logic [2:0] pick_ch(input logic [3:0] m, input logic [1:0] cur,
                                           input logic from_start);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (from_start || i > int'(cur)))
                r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign tmr_tc  = (tmr == 32'd0);
    assign cnt_clr = (state == S_CLEAR);
    assign cnt_en  = (state == S_GATE);
    assign busy    = (state != S_IDLE);

    // Gate length and Hz scale factor for the latched gate selection.
    always_comb begin
        gate_ld = GATE_LD0;
        mult    = 10'd1;
        case (gsel_q)
            2'd1: begin gate_ld = GATE_LD1; mult = 10'd10;   end
            2'd2: begin gate_ld = GATE_LD2; mult = 10'd100;  end
            2'd3: begin gate_ld = GATE_LD3; mult = 10'd1000; end
            default: begin gate_ld = GATE_LD0; mult = 10'd1; end
        endcase
    end

    // Exact 42-bit scaling with saturation to the 32-bit result field.
    always_comb begin
        prod     = 42'(cnt_value) * 42'(mult);
        cap_sat  = |prod[41:32];
        cap_freq = cap_sat ? 32'hFFFF_FFFF : prod[31:0];
        cap_ovf  = ovf_sticky | cap_sat;
        do_load  = ((state == S_CAPTURE) && (!res_valid || res_ack)) ||
                   ((state == S_WAIT_BUF) && res_ack);
    end

    // What happens after a result is loaded: next channel, new sweep or stop.
    always_comb begin
        first_pick  = pick_ch(ch_mask, 2'd0, 1'b1);
        next_pick   = pick_ch(mask_q, cur_ch, 1'b0);
        adv_sel     = 1'b0;
        adv_relatch = 1'b0;
        adv_err     = 1'b0;
        adv_done    = 1'b0;
        adv_ch      = first_pick[1:0];
        if (next_pick[2]) begin
            adv_sel = 1'b1;
            adv_ch  = next_pick[1:0];
        end else if (continuous) begin
            if (ch_mask == 4'd0) begin
                adv_err = 1'b1;
            end else begin
                adv_sel     = 1'b1;
                adv_relatch = 1'b1;
            end
        end else begin
            adv_done = 1'b1;
        end
    end

    // Sequencing FSM with its shared down-counter timer.
    always_ff @(posedge clk_base) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tmr        <= 32'd0;
            mask_q     <= 4'd0;
            cur_ch     <= 2'd0;
            ch_sel     <= 2'd0;
            gsel_q     <= 2'd0;
            pend_freq  <= 32'd0;
            pend_ovf   <= 1'b0;
            err_no_ch  <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            err_no_ch  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (ch_mask == 4'd0) begin
                            err_no_ch <= 1'b1;
                        end else begin
                            mask_q <= ch_mask;
                            cur_ch <= first_pick[1:0];
                            ch_sel <= first_pick[1:0];
                            gsel_q <= gate_sel;
                            tmr    <= SETTLE_LD;
                            state  <= S_SELECT;
                        end
                    end
                end
                S_SELECT: begin
                    if (tmr_tc) begin
                        tmr   <= CLR_LD;
                        state <= S_CLEAR;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                S_CLEAR: begin
                    if (tmr_tc) begin
                        tmr   <= gate_ld;
                        state <= S_GATE;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                S_GATE: begin
                    if (tmr_tc) begin
                        tmr   <= SETTLE_LD;
                        state <= S_HOLD;
                    end else begin
                        tmr <= tmr - 32'd1;
                    end
                end
                S_HOLD: begin
                    if (tmr_tc)
                        state <= S_CAPTURE;
                    else
                        tmr <= tmr - 32'd1;
                end
                S_CAPTURE: begin
                    // cnt_value is only guaranteed stable here, so keep a copy.
                    pend_freq <= cap_freq;
                    pend_ovf  <= cap_ovf;
                    if (!do_load)
                        state <= S_WAIT_BUF;
                end
                S_WAIT_BUF: begin
                end
                default: state <= S_IDLE;
            endcase

            if (do_load) begin
                if (adv_sel) begin
                    state  <= S_SELECT;
                    tmr    <= SETTLE_LD;
                    cur_ch <= adv_ch;
                    ch_sel <= adv_ch;
                    gsel_q <= gate_sel;
                    if (adv_relatch)
                        mask_q <= ch_mask;
                end else begin
                    state <= S_IDLE;
                end
                err_no_ch  <= adv_err;
                sweep_done <= adv_done;
            end
        end
    end

    // Sticky counter overflow across the gate and hold windows.
    always_ff @(posedge clk_base) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (state == S_CLEAR)
            ovf_sticky <= 1'b0;
        else if (((state == S_GATE) || (state == S_HOLD)) && cnt_ovf)
            ovf_sticky <= 1'b1;
    end

    // Result register; an ack and a load in the same cycle keeps it full.
    always_ff @(posedge clk_base) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_ch    <= 2'd0;
            res_freq  <= 32'd0;
            res_ovf   <= 1'b0;
        end else if (do_load) begin
            res_valid <= 1'b1;
            res_ch    <= cur_ch;
            res_freq  <= (state == S_CAPTURE) ? cap_freq : pend_freq;
            res_ovf   <= (state == S_CAPTURE) ? cap_ovf : pend_ovf;
        end else if (res_ack) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_freq_m_sched.sv
// Directed bench for freq_m_sched with a tiny FREQ_BASE so gates stay short.
module tb_freq_m_sched;

    logic        clk_base = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [3:0]  ch_mask = 4'd0;
    logic [1:0]  gate_sel = 2'd0;
    logic [31:0] cnt_value;
    logic        cnt_ovf = 1'b0;
    logic [1:0]  ch_sel;
    logic        cnt_clr;
    logic        cnt_en;
    logic        res_valid;
    logic        res_ack;
    logic [1:0]  res_ch;
    logic [31:0] res_freq;
    logic        res_ovf;
    logic        busy;
    logic        sweep_done;
    logic        err_no_ch;

    logic        man_ack = 1'b0;
    logic        auto_ack = 1'b0;
    logic [31:0] cnt_tbl [4];

    int          n_tests = 0;
    int          n_fail = 0;
    int          en_cnt = 0;
    logic        en_prev = 1'b0;
    logic [1:0]  en_ch_q [$];
    logic [34:0] res_q [$];
    int          n;

    freq_m_sched #(
        .FREQ_BASE(1000),
        .SETTLE(4),
        .CLR_CYCLES(4)
    ) dut (
        .clk_base(clk_base),
        .rst_n(rst_n),
        .start(start),
        .continuous(continuous),
        .ch_mask(ch_mask),
        .gate_sel(gate_sel),
        .cnt_value(cnt_value),
        .cnt_ovf(cnt_ovf),
        .ch_sel(ch_sel),
        .cnt_clr(cnt_clr),
        .cnt_en(cnt_en),
        .res_valid(res_valid),
        .res_ack(res_ack),
        .res_ch(res_ch),
        .res_freq(res_freq),
        .res_ovf(res_ovf),
        .busy(busy),
        .sweep_done(sweep_done),
        .err_no_ch(err_no_ch)
    );

    always #5 clk_base = ~clk_base;

    // Counter model: each channel returns a fixed count.
    assign cnt_value = cnt_tbl[ch_sel];
    assign res_ack   = man_ack | (auto_ack & res_valid);

    // Observe gate length, gated channel order and consumed results.
    always @(negedge clk_base) begin
        if (cnt_en) en_cnt++;
        if (cnt_en && !en_prev) en_ch_q.push_back(ch_sel);
        en_prev = cnt_en;
        if (res_valid && res_ack) res_q.push_back({res_ch, res_ovf, res_freq});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cond(input int which);
        case (which)
            0: return res_valid;
            1: return sweep_done;
            default: return cnt_en;
        endcase
    endfunction

    // Wait (bounded) for 0=res_valid, 1=sweep_done, 2=cnt_en.
    task automatic wait_for(input int which, input int lim, output int cycles);
        cycles = 0;
        while (cycles < lim && !cond(which)) begin
            @(negedge clk_base);
            cycles++;
        end
        check($sformatf("wait_%0d", which), 64'(cond(which)), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_base);
        start = 1'b0;
    endtask

    function automatic logic [63:0] getr(input int i);
        if (i < res_q.size()) return 64'(res_q[i]);
        return '1;
    endfunction

    function automatic logic [63:0] gete(input int i);
        if (i < en_ch_q.size()) return 64'(en_ch_q[i]);
        return '1;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) cnt_tbl[i] = 32'd0;
        repeat (3) @(negedge clk_base);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_cnt_en", 64'(cnt_en), 64'd0);
        check("rst_cnt_clr", 64'(cnt_clr), 64'd0);
        check("rst_ch_sel", 64'(ch_sel), 64'd0);
        check("rst_pulses", 64'({sweep_done, err_no_ch}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_base);

        // Single channel, 1 s gate (1000 cycles), count 737.
        cnt_tbl[0] = 32'd737; ch_mask = 4'b0001; gate_sel = 2'd0; continuous = 1'b0;
        en_cnt = 0;
        pulse_start();
        wait_for(0, 3000, n);
        check("t1_latency", 64'(1 + n), 64'd1014);
        check("t1_gate_len", 64'(en_cnt), 64'd1000);
        check("t1_res_ch", 64'(res_ch), 64'd0);
        check("t1_res_freq", 64'(res_freq), 64'd737);
        check("t1_res_ovf", 64'(res_ovf), 64'd0);
        check("t1_sweep_done", 64'(sweep_done), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        @(negedge clk_base);
        check("t1_done_pulse", 64'(sweep_done), 64'd0);
        check("t1_valid_hold", 64'(res_valid), 64'd1);
        man_ack = 1'b1; @(negedge clk_base); man_ack = 1'b0;
        check("t1_ack_clr", 64'(res_valid), 64'd0);

        // Channels 1 and 3, gate /100 (x100), immediate ack.
        res_q.delete(); en_ch_q.delete();
        cnt_tbl[1] = 32'd5; cnt_tbl[3] = 32'd12; ch_mask = 4'b1010; gate_sel = 2'd2;
        auto_ack = 1'b1;
        pulse_start();
        wait_for(1, 500, n);
        repeat (3) @(negedge clk_base);
        check("t2_nres", 64'(res_q.size()), 64'd2);
        check("t2_res0", getr(0), 64'({2'd1, 1'b0, 32'd500}));
        check("t2_res1", getr(1), 64'({2'd3, 1'b0, 32'd1200}));
        check("t2_ch_seq0", gete(0), 64'd1);
        check("t2_ch_seq1", gete(1), 64'd3);

        // Saturation: 0x0100_0000 * 1000 exceeds 32 bits.
        res_q.delete();
        cnt_tbl[0] = 32'h0100_0000; ch_mask = 4'b0001; gate_sel = 2'd3;
        pulse_start();
        wait_for(1, 200, n);
        repeat (3) @(negedge clk_base);
        check("t3_sat", getr(0), 64'({2'd0, 1'b1, 32'hFFFF_FFFF}));

        // Counter carry-out during the gate sets res_ovf.
        res_q.delete();
        cnt_tbl[0] = 32'd7; gate_sel = 2'd1;
        pulse_start();
        wait_for(2, 200, n);
        cnt_ovf = 1'b1; @(negedge clk_base); cnt_ovf = 1'b0;
        wait_for(1, 300, n);
        repeat (3) @(negedge clk_base);
        check("t3_ovf", getr(0), 64'({2'd0, 1'b1, 32'd70}));

        // Next measurement starts with the sticky flag cleared.
        res_q.delete();
        pulse_start();
        wait_for(1, 300, n);
        repeat (3) @(negedge clk_base);
        check("t3_ovf_clear", getr(0), 64'({2'd0, 1'b0, 32'd70}));

        // Withheld ack: second result waits in WAIT_BUF.
        auto_ack = 1'b0; res_q.delete();
        cnt_tbl[0] = 32'd3; cnt_tbl[1] = 32'd4; ch_mask = 4'b0011; gate_sel = 2'd3;
        pulse_start();
        wait_for(0, 200, n);
        repeat (40) @(negedge clk_base);
        check("t4_valid", 64'(res_valid), 64'd1);
        check("t4_hold_ch", 64'(res_ch), 64'd0);
        check("t4_hold_freq", 64'(res_freq), 64'd3000);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_cnt_en", 64'(cnt_en), 64'd0);
        man_ack = 1'b1; @(negedge clk_base); man_ack = 1'b0;
        check("t4_ch2", 64'(res_ch), 64'd1);
        check("t4_freq2", 64'(res_freq), 64'd4000);
        check("t4_valid2", 64'(res_valid), 64'd1);
        check("t4_done", 64'(sweep_done), 64'd1);
        check("t4_busy2", 64'(busy), 64'd0);
        man_ack = 1'b1; @(negedge clk_base); man_ack = 1'b0;
        check("t4_drain", 64'(res_valid), 64'd0);

        // Empty mask, then start while busy.
        ch_mask = 4'b0000;
        pulse_start();
        check("t5_err", 64'(err_no_ch), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        @(negedge clk_base);
        check("t5_err_pulse", 64'(err_no_ch), 64'd0);
        auto_ack = 1'b1; res_q.delete(); en_ch_q.delete();
        cnt_tbl[0] = 32'd9; ch_mask = 4'b0001; gate_sel = 2'd3;
        pulse_start();
        repeat (3) @(negedge clk_base);
        ch_mask = 4'b0010;
        pulse_start();
        wait_for(1, 200, n);
        repeat (3) @(negedge clk_base);
        check("t5_nres", 64'(res_q.size()), 64'd1);
        check("t5_res0", getr(0), 64'({2'd0, 1'b0, 32'd9000}));
        check("t5_ngate", 64'(en_ch_q.size()), 64'd1);

        // Reset in the middle of a long gate with a result still held.
        auto_ack = 1'b0; ch_mask = 4'b0001; gate_sel = 2'd3;
        pulse_start();
        wait_for(1, 200, n);
        check("t6_pre_valid", 64'(res_valid), 64'd1);
        gate_sel = 2'd0;
        pulse_start();
        wait_for(2, 200, n);
        repeat (10) @(negedge clk_base);
        rst_n = 1'b0;
        @(negedge clk_base);
        check("t6_cnt_en", 64'(cnt_en), 64'd0);
        check("t6_valid", 64'(res_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ch_sel", 64'(ch_sel), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_base);
        auto_ack = 1'b1; res_q.delete(); en_ch_q.delete();
        gate_sel = 2'd3;
        pulse_start();
        wait_for(1, 200, n);
        repeat (3) @(negedge clk_base);
        check("t6_res", getr(0), 64'({2'd0, 1'b0, 32'd9000}));
        check("t6_first_ch", gete(0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
